// File: rtl/noc_pe_traffic.sv
// ---------------------------------------------------------------------------
// noc_pe_traffic
//
// Processing-element traffic endpoint for the hierarchical NoC.  The
// injection side issues PktLmit packets, each addressed by a synthetic
// traffic pattern and stamped with the cycle it was launched.  The ejection
// side sinks every packet the network delivers, counts it and reports how
// many cycles it spent in flight.
//
// Ports
//   clk             PE clock, all logic on the rising edge
//   rst             asynchronous active-high reset
//   i_data          flit arriving from the network {dest, timestamp}
//   i_data_valid    i_data valid, one cycle per delivered packet
//   o_data_ready    PE can accept an arriving flit (high outside reset)
//   o_data          injected flit {dest, timestamp}
//   o_data_valid    o_data valid
//   i_data_ready    network accepts o_data
//   done            global stop request, halts injection
//   o_rx_count      packets received since reset (saturating)
//   o_last_latency  latency of the most recently received packet
//   o_addr_err      sticky: a packet arrived addressed to another PE
// ---------------------------------------------------------------------------
module noc_pe_traffic #(
    parameter int          address      = 0,
    parameter int          numPE        = 4,
    parameter int          AddressWidth = $clog2(numPE),
    parameter int          DataWidth    = 32,
    parameter int          TotalWidth   = DataWidth + AddressWidth,
    parameter int unsigned PktLmit      = 100,
    parameter string       Pattern      = "Tornado"
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [TotalWidth-1:0] i_data,
    input  logic                  i_data_valid,
    output logic                  o_data_ready,
    output logic [TotalWidth-1:0] o_data,
    output logic                  o_data_valid,
    input  logic                  i_data_ready,
    input  logic                  done,
    output logic [31:0]           o_rx_count,
    output logic [DataWidth-1:0]  o_last_latency,
    output logic                  o_addr_err
);

    // Pattern selection is resolved at elaboration time.  Every pattern
    // except Uniform yields one fixed destination; unknown pattern names
    // fall back to Tornado.
    localparam bit IsUniform = (Pattern == "Uniform");
    localparam int TornadoDest   = (address + numPE / 2 - 1) % numPE;
    localparam int NeighbourDest = (address + 1) % numPE;
    localparam logic [AddressWidth-1:0] FixedDest =
        (Pattern == "Neighbour")  ? AddressWidth'(NeighbourDest) :
        (Pattern == "Complement") ? AddressWidth'(~address)      :
                                    AddressWidth'(TornadoDest);
    localparam logic [AddressWidth-1:0] OwnAddr  = AddressWidth'(address);
    localparam logic [15:0]             LfsrSeed = 16'(address + 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        FINISH
    } stateT;

    stateT                   r_state;
    stateT                   w_nextState;
    logic                    w_load;
    logic                    w_nextValid;
    logic                    w_transfer;
    logic                    w_rxFire;
    logic [15:0]             w_lfsrNext;
    logic [AddressWidth-1:0] w_dest;

    logic [DataWidth-1:0]    r_tsCount;
    logic [31:0]             r_sentCount;
    logic [15:0]             r_lfsr;
    logic [TotalWidth-1:0]   r_data;
    logic                    r_dataValid;
    logic                    r_dataReady;
    logic [31:0]             r_rxCount;
    logic [DataWidth-1:0]    r_lastLatency;
    logic                    r_addrErr;

    assign w_transfer = r_dataValid & i_data_ready;
    assign w_rxFire   = i_data_valid & r_dataReady;

    // Fibonacci LFSR with taps 16,14,13,11, shifting toward the MSB.
    assign w_lfsrNext = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};

    // A flit loaded on the same edge as a transfer must see the LFSR value
    // after that transfer's advance, so the Uniform destination looks ahead.
    assign w_dest = IsUniform ? (w_transfer ? w_lfsrNext[AddressWidth-1:0]
                                            : r_lfsr[AddressWidth-1:0])
                              : FixedDest;

    // State register of the injection machine.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state, next valid and flit-load decision.  done overrides
    // everything else; a transfer on that same edge is still counted by the
    // sent counter because that counter looks only at the handshake.
    always_comb begin
        w_nextState = r_state;
        w_nextValid = r_dataValid;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (PktLmit == 0) begin
                    w_nextState = FINISH;
                    w_nextValid = 1'b0;
                end else begin
                    w_nextState = SEND;
                    w_nextValid = 1'b1;
                    w_load      = 1'b1;
                end
            end
            SEND: begin
                if (w_transfer) begin
                    if ((r_sentCount + 32'd1) == PktLmit) begin
                        w_nextState = FINISH;
                        w_nextValid = 1'b0;
                    end else begin
                        w_load = 1'b1;
                    end
                end
            end
            FINISH: begin
                w_nextValid = 1'b0;
            end
            default: begin
                w_nextState = FINISH;
                w_nextValid = 1'b0;
            end
        endcase
        if (done) begin
            w_nextState = FINISH;
            w_nextValid = 1'b0;
            w_load      = 1'b0;
        end
    end

    // Injection datapath: free-running timestamp, sent counter, LFSR and
    // the registered outgoing flit.  The stamp is the counter value on the
    // edge that raises (or reloads) o_data_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tsCount   <= '0;
            r_sentCount <= '0;
            r_lfsr      <= LfsrSeed;
            r_data      <= '0;
            r_dataValid <= 1'b0;
        end else begin
            r_tsCount   <= r_tsCount + 1'b1;
            r_dataValid <= w_nextValid;
            if (w_transfer) begin
                r_sentCount <= r_sentCount + 32'd1;
                r_lfsr      <= w_lfsrNext;
            end
            if (w_load) begin
                r_data <= {w_dest, r_tsCount};
            end
        end
    end

    // Ejection side: always ready once out of reset so the network can
    // drain even after injection has stopped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dataReady   <= 1'b0;
            r_rxCount     <= '0;
            r_lastLatency <= '0;
            r_addrErr     <= 1'b0;
        end else begin
            r_dataReady <= 1'b1;
            if (w_rxFire) begin
                if (r_rxCount != 32'hFFFF_FFFF) begin
                    r_rxCount <= r_rxCount + 32'd1;
                end
                r_lastLatency <= r_tsCount - i_data[DataWidth-1:0];
                if (i_data[TotalWidth-1:DataWidth] != OwnAddr) begin
                    r_addrErr <= 1'b1;
                end
            end
        end
    end

    assign o_data         = r_data;
    assign o_data_valid   = r_dataValid;
    assign o_data_ready   = r_dataReady;
    assign o_rx_count     = r_rxCount;
    assign o_last_latency = r_lastLatency;
    assign o_addr_err     = r_addrErr;

endmodule

// File: tb/tb_noc_pe_traffic.sv
// ---------------------------------------------------------------------------
// tb_noc_pe_traffic
//
// Testbench for noc_pe_traffic.  A main endpoint (address 0, Tornado) is
// driven with random backpressure and random arriving flits; four more
// endpoints at address 2 (Neighbour, Complement, Tornado, Uniform) and one
// with a zero packet limit share the clock, reset, ready and done so their
// injection timing is identical and only the destinations differ.
// ---------------------------------------------------------------------------
module tb_noc_pe_traffic;

   localparam int DW  = 32;
   localparam int AW  = 2;
   localparam int TW  = DW + AW;
   localparam int LIM = 100;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [TW-1:0] inData = '0;
   logic          inValid = 1'b0;
   logic          netReady = 1'b0;
   logic          done = 1'b0;

   logic          outReady;
   logic [TW-1:0] outData;
   logic          outValid;
   logic [31:0]   rxCount;
   logic [DW-1:0] lastLat;
   logic          addrErr;

   logic          xReady [5];
   logic [TW-1:0] xData  [5];
   logic          xValid [5];
   logic [31:0]   xRx    [5];
   logic [DW-1:0] xLat   [5];
   logic          xErr   [5];

   int vectors     = 0;
   int miscompares = 0;

   // Behavioural reference state: what the endpoint should be showing now.
   logic [DW-1:0] mCycle;
   bit            mStarted;
   bit            mValid;
   int            mSent;
   logic [DW-1:0] mTs;
   logic [15:0]   mLfsrU;
   logic [AW-1:0] mDestU;
   int unsigned   mRx;
   logic [DW-1:0] mLat;
   bit            mErr;
   int            dutSent;

   always #5 clk = ~clk;

   noc_pe_traffic #(.address(0), .numPE(4), .PktLmit(LIM), .Pattern("Tornado")) u_dut (
      .clk(clk), .rst(rst), .i_data(inData), .i_data_valid(inValid),
      .o_data_ready(outReady), .o_data(outData), .o_data_valid(outValid),
      .i_data_ready(netReady), .done(done), .o_rx_count(rxCount),
      .o_last_latency(lastLat), .o_addr_err(addrErr));

   noc_pe_traffic #(.address(2), .numPE(4), .PktLmit(LIM), .Pattern("Neighbour")) u_nb (
      .clk(clk), .rst(rst), .i_data('0), .i_data_valid(1'b0),
      .o_data_ready(xReady[0]), .o_data(xData[0]), .o_data_valid(xValid[0]),
      .i_data_ready(netReady), .done(done), .o_rx_count(xRx[0]),
      .o_last_latency(xLat[0]), .o_addr_err(xErr[0]));

   noc_pe_traffic #(.address(2), .numPE(4), .PktLmit(LIM), .Pattern("Complement")) u_cp (
      .clk(clk), .rst(rst), .i_data('0), .i_data_valid(1'b0),
      .o_data_ready(xReady[1]), .o_data(xData[1]), .o_data_valid(xValid[1]),
      .i_data_ready(netReady), .done(done), .o_rx_count(xRx[1]),
      .o_last_latency(xLat[1]), .o_addr_err(xErr[1]));

   noc_pe_traffic #(.address(2), .numPE(4), .PktLmit(LIM), .Pattern("Tornado")) u_tn (
      .clk(clk), .rst(rst), .i_data('0), .i_data_valid(1'b0),
      .o_data_ready(xReady[2]), .o_data(xData[2]), .o_data_valid(xValid[2]),
      .i_data_ready(netReady), .done(done), .o_rx_count(xRx[2]),
      .o_last_latency(xLat[2]), .o_addr_err(xErr[2]));

   noc_pe_traffic #(.address(2), .numPE(4), .PktLmit(LIM), .Pattern("Uniform")) u_un (
      .clk(clk), .rst(rst), .i_data('0), .i_data_valid(1'b0),
      .o_data_ready(xReady[3]), .o_data(xData[3]), .o_data_valid(xValid[3]),
      .i_data_ready(netReady), .done(done), .o_rx_count(xRx[3]),
      .o_last_latency(xLat[3]), .o_addr_err(xErr[3]));

   noc_pe_traffic #(.address(0), .numPE(4), .PktLmit(0), .Pattern("Tornado")) u_zero (
      .clk(clk), .rst(rst), .i_data('0), .i_data_valid(1'b0),
      .o_data_ready(xReady[4]), .o_data(xData[4]), .o_data_valid(xValid[4]),
      .i_data_ready(netReady), .done(done), .o_rx_count(xRx[4]),
      .o_last_latency(xLat[4]), .o_addr_err(xErr[4]));

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
      end
   endtask

   // One step of the 16-bit Fibonacci LFSR (taps 16,14,13,11).
   function automatic logic [15:0] lfsrStep(input logic [15:0] v);
      logic [15:0] fb;
      fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 16'd1;
      return (v << 1) | fb;
   endfunction

   function automatic logic [TW-1:0] makeFlit(input logic [AW-1:0] dst, input logic [DW-1:0] ts);
      return {dst, ts};
   endfunction

   task automatic modelReset();
      mCycle   = '0;
      mStarted = 1'b0;
      mValid   = 1'b0;
      mSent    = 0;
      mTs      = '0;
      mLfsrU   = 16'd3;
      mDestU   = '0;
      mRx      = 0;
      mLat     = '0;
      mErr     = 1'b0;
      dutSent  = 0;
   endtask

   // Compare every endpoint against the reference state (called at negedge).
   task automatic observe();
      logic [AW-1:0] expDest [4];
      expDest[0] = 2'd3;
      expDest[1] = 2'd1;
      expDest[2] = 2'd3;
      expDest[3] = mDestU;
      checkOutput("valid", outValid, mValid);
      if (mValid) checkOutput("data", outData, makeFlit(2'd1, mTs));
      checkOutput("ready", outReady, mCycle != 0);
      checkOutput("rxCount", rxCount, mRx);
      checkOutput("latency", lastLat, mLat);
      checkOutput("addrErr", addrErr, mErr);
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("valid%0d", i), xValid[i], mValid);
         if (mValid) checkOutput($sformatf("data%0d", i), xData[i], makeFlit(expDest[i], mTs));
      end
      checkOutput("zeroLimitValid", xValid[4], 1'b0);
   endtask

   // Check the current outputs, drive one cycle of inputs, advance the
   // reference model across the coming rising edge and wait for the next
   // falling edge.
   task automatic applyStimulus(input bit rdy, input bit dn, input bit rxv, input logic [TW-1:0] rxFlit);
      bit transfer;
      observe();
      netReady = rdy;
      done     = dn;
      inValid  = rxv;
      inData   = rxFlit;
      if (outValid && rdy) dutSent++;
      transfer = mValid && rdy;
      if (transfer) begin
         mSent++;
         mLfsrU = lfsrStep(mLfsrU);
      end
      if (dn) begin
         mValid   = 1'b0;
         mStarted = 1'b1;
      end else if (!mStarted || transfer) begin
         mStarted = 1'b1;
         if (mSent == LIM) begin
            mValid = 1'b0;
         end else begin
            mValid = 1'b1;
            mTs    = mCycle;
            mDestU = mLfsrU[AW-1:0];
         end
      end
      if (rxv && mCycle != 0) begin
         if (mRx != 32'hFFFF_FFFF) mRx++;
         mLat = mCycle - rxFlit[DW-1:0];
         if (rxFlit[TW-1:DW] != 2'd0) mErr = 1'b1;
      end
      mCycle++;
      @(posedge clk);
      @(negedge clk);
   endtask

   // Assert reset between clock edges, confirm that outputs clear without
   // waiting for an edge, then release on a falling edge.
   task automatic resetDut();
      #2;
      rst      = 1'b1;
      done     = 1'b0;
      inValid  = 1'b0;
      netReady = 1'b0;
      #1;
      checkOutput("rstValid", outValid, 1'b0);
      checkOutput("rstData", outData, '0);
      checkOutput("rstReady", outReady, 1'b0);
      checkOutput("rstRx", rxCount, '0);
      checkOutput("rstLat", lastLat, '0);
      checkOutput("rstErr", addrErr, 1'b0);
      checkOutput("rstUniValid", xValid[3], 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      modelReset();
   endtask

   function automatic logic [TW-1:0] randomFlit(input logic [AW-1:0] dst);
      logic [DW-1:0] ts;
      if ($urandom_range(0, 4) == 0) ts = $urandom();
      else ts = mCycle - DW'($urandom_range(0, 60));
      return makeFlit(dst, ts);
   endfunction

   initial begin
      modelReset();
      @(negedge clk);

      // Run 1: random backpressure and arrivals, a fixed 5-cycle stall,
      // an exact latency-7 arrival and a misaddressed arrival.
      resetDut();
      for (int c = 0; c < 260; c++) begin
         bit rdy;
         bit rxv;
         logic [TW-1:0] flit;
         rdy  = (c >= 30 && c < 35) ? 1'b0 : ($urandom_range(0, 9) != 0);
         rxv  = ($urandom_range(0, 2) == 0);
         flit = randomFlit(2'd0);
         if (c == 60) begin
            rxv  = 1'b1;
            flit = makeFlit(2'd0, mCycle - 32'd7);
         end else if (c == 120) begin
            rxv  = 1'b1;
            flit = makeFlit(2'd3, mCycle - 32'd3);
         end
         applyStimulus(rdy, 1'b0, rxv, flit);
         if (c == 60) begin
            checkOutput("latency7", lastLat, 32'd7);
            checkOutput("errClear", addrErr, 1'b0);
         end
         if (c == 120) checkOutput("errSet", addrErr, 1'b1);
      end
      checkOutput("pktTotalRun1", dutSent, LIM);

      // Run 2: stop request after 10 transfers; the transfer on the done
      // edge still counts, then injection stays off while receiving goes on.
      resetDut();
      for (int c = 0; c < 11; c++) applyStimulus(1'b1, 1'b0, 1'b0, '0);
      applyStimulus(1'b1, 1'b1, 1'b0, '0);
      checkOutput("doneSent", dutSent, 11);
      checkOutput("doneValid", outValid, 1'b0);
      for (int c = 0; c < 20; c++) applyStimulus(1'b1, 1'b0, 1'b1, randomFlit(2'd0));
      checkOutput("doneRx", rxCount, 32'd20);
      checkOutput("doneReady", outReady, 1'b1);

      // Run 3: reset in the middle of a stream, then a full restart.
      resetDut();
      for (int c = 0; c < 30; c++) applyStimulus(1'b1, 1'b0, 1'b0, '0);
      resetDut();
      for (int c = 0; c < 110; c++) begin
         applyStimulus(1'b1, 1'b0, ($urandom_range(0, 3) == 0), randomFlit(2'd0));
         if (c == 0) checkOutput("restartTs", outData, makeFlit(2'd1, 32'd0));
      end
      checkOutput("pktTotalRun3", dutSent, LIM);

      for (int i = 0; i < 5; i++) begin
         checkOutput($sformatf("idleRx%0d", i), xRx[i], '0);
         checkOutput($sformatf("idleErr%0d", i), xErr[i], 1'b0);
         checkOutput($sformatf("idleLat%0d", i), xLat[i], '0);
         checkOutput($sformatf("idleReady%0d", i), xReady[i], 1'b1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/noc_pe_traffic.md
Name: noc_pe_traffic

Overview:
- Processing-element traffic endpoint for the hierarchical NoC. One instance attaches to each PE port of the network.
- Injection side: issues exactly PktLmit packets to destinations chosen by a synthetic traffic pattern, each stamped with its injection cycle.
- Ejection side: sinks packets from the network, counts them and computes per-packet latency.
- Runs on the PE clock domain; the NoC handles any clock crossing.

Parameters:
- address, 0, this PE's network address (0..numPE-1).
- numPE, 4, number of PEs in the network; must be a power of two, at least 2.
- AddressWidth, $clog2(numPE), width of the destination field.
- DataWidth, 32, payload width.
- TotalWidth, DataWidth+AddressWidth, flit width.
- PktLmit, 100, number of packets to inject after reset.
- Pattern, "Tornado", traffic pattern string: "Tornado", "Neighbour", "Complement" or "Uniform". Any other value behaves as "Tornado".

Ports:
- clk  in  1  PE clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_data  in  TotalWidth  flit arriving from the network.
- i_data_valid  in  1  i_data valid; one cycle per delivered packet.
- o_data_ready  out  1  PE can accept an arriving flit.
- o_data  out  TotalWidth  injected flit.
- o_data_valid  out  1  o_data valid.
- i_data_ready  in  1  network accepts o_data.
- done  in  1  global stop request, active-high.
- o_rx_count  out  32  packets received since reset.
- o_last_latency  out  DataWidth  latency in cycles of the most recently received packet.
- o_addr_err  out  1  sticky flag: a packet arrived whose destination field is not `address`.

Behaviour:
- Flit format:
  - o_data[TotalWidth-1:DataWidth] = destination address.
  - o_data[DataWidth-1:0] = injection timestamp.
- Timestamp counter (DataWidth bits):
  - Reset to 0; increments every cycle; wraps modulo 2^DataWidth.
  - The timestamp of a packet is the counter value in the cycle its o_data_valid first rises.
- Destination by pattern, with N = numPE:
  - Tornado: (address + N/2 - 1) mod N.
  - Neighbour: (address + 1) mod N.
  - Complement: bitwise NOT of address, AddressWidth bits.
  - Uniform: low AddressWidth bits of a 16-bit Fibonacci LFSR.
    - Taps 16,14,13,11.
    - Seeded with address+1 at reset.
    - Advances once per accepted packet.
    - Self-destination is allowed.
- Reset (asynchronous, takes effect immediately):
  - o_data_valid=0, o_data=0, o_data_ready=0, o_rx_count=0, o_last_latency=0, o_addr_err=0.
  - Sent counter, timestamp counter and LFSR are re-initialised.
  - Reset mid-operation discards any pending flit; after release, injection restarts from packet 0.
- Injection state machine (IDLE, SEND, FINISH):
  - IDLE: entered on reset. On the first clock edge with rst low, load the flit and go to SEND with o_data_valid=1.
  - SEND: o_data and o_data_valid are held stable until a rising edge with o_data_valid & i_data_ready (transfer). On transfer, the sent counter increments.
    - If sent == PktLmit: o_data_valid=0, go to FINISH.
    - Otherwise: load the next flit in the same edge, so back-to-back injection gives one packet per cycle while i_data_ready stays high.
  - FINISH: o_data_valid stays 0 until reset.
  - done=1 in any state forces o_data_valid=0 on the next edge and moves to FINISH. A flit transferred in the same edge done is sampled still counts.
  - PktLmit=0: go directly from IDLE to FINISH; no packet is ever issued.
- Ejection:
  - o_data_ready=1 every cycle outside reset, including FINISH and after done, so the network can always drain.
  - On each edge with i_data_valid & o_data_ready:
    - o_rx_count increments (saturating at 2^32-1).
    - o_last_latency = (timestamp counter - i_data[DataWidth-1:0]) mod 2^DataWidth.
    - If i_data[TotalWidth-1:DataWidth] != address, o_addr_err is set; it clears only on reset.
  - The ejection path is independent of the injection path; simultaneous inject and receive in the same cycle are both processed.
- Outputs are registered; no combinational path from i_data_ready to o_data_valid.

Test Plan:
- Reset release, address=0, numPE=4, Tornado, i_data_ready=1 -> o_data_valid rises one cycle after rst falls; dest field=1; timestamps 0,1,2…; exactly 100 accepted packets, then o_data_valid=0 permanently.
- Backpressure: hold i_data_ready=0 for 5 cycles mid-stream -> o_data and o_data_valid unchanged across those cycles; the sent count does not advance.
- Patterns with address=2, numPE=4 -> Neighbour dest=3; Complement dest=1; Tornado dest=3; Uniform dest sequence matches the LFSR reference model seeded with 3.
- Receive flit {dest=address, ts=T} when the timestamp counter equals T+7 -> o_last_latency=7, o_rx_count increments by 1, o_addr_err stays 0. A flit with the wrong dest sets o_addr_err.
- Assert done after 10 transfers -> o_data_valid=0 next cycle; no more injection; o_data_ready stays 1 and receive counting continues.
- Assert rst mid-stream -> outputs clear immediately, without waiting for a clock edge; after release, injection restarts with the timestamp counter at 0 and 100 new packets.
